// File: rtl/nec_pkg.sv
// Shared NEC definitions: scheduler state encoding, nominal frame period and the
// frame-length helper also used by the transmitter timing constants.
package nec_pkg;

  localparam int NEC_FRAME_US = 108000;

  typedef enum logic [2:0] {
    HOLDOFF,
    IDLE,
    SETUP,
    SEND,
    WAIT
  } sched_state_e;

  // Integer MHz keeps the product exact and well inside 32 bits for NEC periods.
  function automatic int nec_frame_cycles(input int clk_freq, input int frame_us);
    return (clk_freq / 1_000_000) * frame_us;
  endfunction

endpackage

// File: rtl/nec_req_arbiter.sv
// Picks one pending requester: round-robin from ptr when NEC_SCHED_RR_EN is defined,
// otherwise fixed priority with the lowest index winning.
module nec_req_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
`ifdef NEC_SCHED_RR_EN
  input  logic [IDX_W-1:0] ptr,
`endif
  output logic [N_REQ-1:0] grant,
  output logic             valid
);

  logic found;

`ifdef NEC_SCHED_RR_EN
  logic [IDX_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = IDX_W'((int'(ptr) + i) % N_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
`else
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

  assign valid = |req;

endmodule

// File: rtl/nec_tx_scheduler.sv
// Shares one NEC IR transmitter among N_REQ sources and owns the send-to-send frame spacing.
// Define NEC_SCHED_RR_EN for round-robin arbitration; the default is fixed priority.
module nec_tx_scheduler
  import nec_pkg::*;
#(
  parameter int CLK_FREQ     = 125_000_000,
  parameter int N_REQ        = 4,
  parameter int FRAME_US     = NEC_FRAME_US,
  parameter int SETUP_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [N_REQ-1:0]         req,
  input  logic [8*N_REQ-1:0]       req_addr,
  input  logic [8*N_REQ-1:0]       req_code,
  output logic [N_REQ-1:0]         ack,
  output logic [7:0]               tx_addr,
  output logic [7:0]               tx_code,
  output logic                     tx_send,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id
);

  localparam int FRAME_CYCLES = nec_frame_cycles(CLK_FREQ, FRAME_US);
  localparam int CNT_W        = $clog2(FRAME_CYCLES + 1);
  localparam int IDX_W        = $clog2(N_REQ);

  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  sched_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [7:0]       tx_addr_q, tx_addr_d;
  logic [7:0]       tx_code_q, tx_code_d;
  logic [IDX_W-1:0] grant_id_q, grant_id_d;
  logic [IDX_W-1:0] win_idx;
  logic [N_REQ-1:0] arb_grant;
  logic             arb_valid;
  logic             grant_fire;

`ifdef NEC_SCHED_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
`endif

  nec_req_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .req  (req),
`ifdef NEC_SCHED_RR_EN
    .ptr  (ptr_q),
`endif
    .grant(arb_grant),
    .valid(arb_valid)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_grant[i]) win_idx = IDX_W'(i);
    end
  end

  assign grant_fire = (state_q == IDLE) && en && arb_valid;
  assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HOLDOFF;
      cnt_q      <= '0;
      tx_addr_q  <= '0;
      tx_code_q  <= '0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_addr_q  <= tx_addr_d;
      tx_code_q  <= tx_code_d;
      grant_id_q <= grant_id_d;
    end
  end

`ifdef NEC_SCHED_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

  // The SEND cycle is cycle 0 of the frame period, so SEND plus WAIT spans FRAME_CYCLES.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_addr_d  = tx_addr_q;
    tx_code_d  = tx_code_q;
    grant_id_d = grant_id_q;
`ifdef NEC_SCHED_RR_EN
    ptr_d      = ptr_q;
`endif
    case (state_q)
      HOLDOFF: begin
        if (cnt_q == FRAME_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      IDLE: begin
        if (grant_fire) begin
          state_d    = SETUP;
          cnt_d      = '0;
          tx_addr_d  = req_addr[{win_idx, 3'b000} +: 8];
          tx_code_d  = req_code[{win_idx, 3'b000} +: 8];
          grant_id_d = win_idx;
`ifdef NEC_SCHED_RR_EN
          ptr_d = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
`endif
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = SEND;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      SEND: begin
        state_d = WAIT;
        cnt_d   = cnt_inc;
      end
      WAIT: begin
        if (cnt_q == FRAME_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = HOLDOFF;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    ack     = '0;
    tx_send = 1'b0;
    busy    = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (grant_fire) ack = arb_grant;
      end
      SEND:    tx_send = 1'b1;
      default: ;
    endcase
  end

  assign tx_addr  = tx_addr_q;
  assign tx_code  = tx_code_q;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_nec_tx_scheduler.sv
// Self-checking bench for nec_tx_scheduler: a vector table plus multi-cycle sequences,
// with a tx_send scoreboard. Define NEC_SCHED_RR_EN to expect round-robin grant order.
`timescale 1ns/1ps
module tb_nec_tx_scheduler;

  localparam int N_REQ        = 4;
  localparam int FRAME_CYCLES = 200;
  localparam int SETUP_CYCLES = 2;
  localparam int SEND_GAP     = FRAME_CYCLES + SETUP_CYCLES + 1;

  typedef struct {
    logic [3:0] req;
    logic [7:0] addr;
    logic [7:0] code;
    logic [3:0] exp_ack;
    logic [1:0] exp_id;
  } vec_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] code;
    logic [1:0] id;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [3:0]  req;
  logic [31:0] req_addr;
  logic [31:0] req_code;
  logic [3:0]  ack;
  logic [7:0]  tx_addr;
  logic [7:0]  tx_code;
  logic        tx_send;
  logic        busy;
  logic [1:0]  grant_id;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb_q[$];
  vec_t vecs[6];
  int   order[5];

  logic [7:0] addr_h1 = '0, addr_h2 = '0, code_h1 = '0, code_h2 = '0;
  int         last_send = 0;
  bit         have_prev = 1'b0;

  nec_tx_scheduler #(
    .CLK_FREQ    (1_000_000),
    .N_REQ       (N_REQ),
    .FRAME_US    (200),
    .SETUP_CYCLES(SETUP_CYCLES)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .req_addr(req_addr),
    .req_code(req_code),
    .ack     (ack),
    .tx_addr (tx_addr),
    .tx_code (tx_code),
    .tx_send (tx_send),
    .busy    (busy),
    .grant_id(grant_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input logic [7:0] a, input logic [7:0] c, input logic [1:0] id);
    exp_t e;
    e.addr = a;
    e.code = c;
    e.id   = id;
    sb_q.push_back(e);
  endtask

  task automatic setSlot(input int i, input logic [7:0] a, input logic [7:0] c);
    req_addr[8*i +: 8] = a;
    req_code[8*i +: 8] = c;
  endtask

  // Scoreboard side: every tx_send must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      have_prev = 1'b0;
    end else if (tx_send) begin
      checkOutput("send_addr_setup", {addr_h2, addr_h1}, {tx_addr, tx_addr});
      checkOutput("send_code_setup", {code_h2, code_h1}, {tx_code, tx_code});
      checkOutput("send_pending", 32'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checkOutput("send_addr", tx_addr, e.addr);
        checkOutput("send_code", tx_code, e.code);
        checkOutput("send_id", grant_id, e.id);
      end
      if (have_prev) checkOutput("send_spacing_min", 32'((cyc - last_send) >= SEND_GAP), 1);
      last_send = cyc;
      have_prev = 1'b1;
    end
    addr_h2 = addr_h1;
    addr_h1 = tx_addr;
    code_h2 = code_h1;
    code_h1 = tx_code;
  end

  task automatic waitIdle();
    int n = 0;
    while (busy && n < 3*FRAME_CYCLES) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_reached", busy, 0);
  endtask

  // Waits for ack, then for tx_send; exp_wait < 0 skips the ack-latency check.
  task automatic runGrant(input string name, input logic [3:0] exp_ack, input int exp_wait,
                          input bit drop, output int send_cyc);
    int n = 0;
    int m = 0;
    while (ack == 4'b0 && n < 2*FRAME_CYCLES + 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_ack"}, ack, exp_ack);
    if (exp_wait >= 0) checkOutput({name, "_ack_wait"}, n, exp_wait);
    do begin
      @(negedge clk);
      m++;
      if (m == 1 && drop) begin
        req      = '0;
        req_addr = ~req_addr;
        req_code = ~req_code;
      end
    end while (!tx_send && m < 10);
    checkOutput({name, "_ack_to_send"}, m, SETUP_CYCLES + 1);
    send_cyc = cyc;
    @(negedge clk);
    checkOutput({name, "_send_pulse"}, tx_send, 0);
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    int sc;
    waitIdle();
    for (int i = 0; i < N_REQ; i++) setSlot(i, 8'hC0 + 8'(i), 8'hD0 + 8'(i));
    setSlot(int'(v.exp_id), v.addr, v.code);
    pushExp(v.addr, v.code, v.exp_id);
    req = v.req;
    #1;
    runGrant($sformatf("vec%0d", idx), v.exp_ack, 0, 1'b1, sc);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int sc, prev_sc, ack_count, send_count;

    vecs[0] = '{4'b0100, 8'h00, 8'h45, 4'b0100, 2'd2};
    vecs[1] = '{4'b1000, 8'hA5, 8'h5A, 4'b1000, 2'd3};
    vecs[2] = '{4'b0010, 8'h12, 8'h34, 4'b0010, 2'd1};
`ifdef NEC_SCHED_RR_EN
    vecs[3] = '{4'b0110, 8'h3C, 8'hC3, 4'b0100, 2'd2};
    vecs[4] = '{4'b1001, 8'h5E, 8'hE5, 4'b1000, 2'd3};
    order   = '{0, 1, 2, 3, 0};
`else
    vecs[3] = '{4'b0110, 8'h3C, 8'hC3, 4'b0010, 2'd1};
    vecs[4] = '{4'b1001, 8'h5E, 8'hE5, 4'b0001, 2'd0};
    order   = '{0, 0, 0, 0, 0};
`endif
    vecs[5] = '{4'b1000, 8'hFF, 8'h00, 4'b1000, 2'd3};

    // Reset state and startup holdoff with a request already pending.
    rst_n    = 1'b0;
    en       = 1'b1;
    req_addr = 32'hC3C2C1C0;
    req_code = 32'hD3D2D1D0;
    setSlot(0, 8'h31, 8'h41);
    req = 4'b0001;
    pushExp(8'h31, 8'h41, 2'd0);
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busy, 1);
    checkOutput("reset_ack", ack, 0);
    checkOutput("reset_tx_send", tx_send, 0);
    checkOutput("reset_tx_addr", tx_addr, 0);
    checkOutput("reset_tx_code", tx_code, 0);
    checkOutput("reset_grant_id", grant_id, 0);
    rst_n = 1'b1;
    #1;
    runGrant("holdoff", 4'b0001, FRAME_CYCLES, 1'b1, sc);

    for (int i = 0; i < 6; i++) applyStimulus(i, vecs[i]);

    // All sources held: grant order and exact send-to-send spacing.
    waitIdle();
    for (int i = 0; i < N_REQ; i++) setSlot(i, 8'h10 + 8'(i), 8'h20 + 8'(i));
    for (int g = 0; g < 5; g++) pushExp(8'h10 + 8'(order[g]), 8'h20 + 8'(order[g]), 2'(order[g]));
    req = 4'b1111;
    #1;
    prev_sc = 0;
    for (int g = 0; g < 5; g++) begin
      runGrant($sformatf("all%0d", g), 4'b0001 << order[g], (g == 0) ? 0 : -1, g == 4, sc);
      if (g > 0) checkOutput($sformatf("all%0d_gap", g), sc - prev_sc, SEND_GAP);
      prev_sc = sc;
    end

    // Enable low holds IDLE; raising it grants straight away.
    en = 1'b0;
    waitIdle();
    setSlot(1, 8'h5C, 8'hC5);
    pushExp(8'h5C, 8'hC5, 2'd1);
    req = 4'b0010;
    ack_count = 0;
    repeat (20) begin
      @(negedge clk);
      if (ack != 4'b0) ack_count++;
    end
    checkOutput("en_low_acks", ack_count, 0);
    checkOutput("en_low_busy", busy, 0);
    en = 1'b1;
    #1;
    runGrant("en_rise", 4'b0010, 0, 1'b1, sc);

    // A one-cycle request during WAIT is never granted.
    repeat (50) @(negedge clk);
    req = 4'b1000;
    @(negedge clk);
    req = 4'b0000;
    ack_count  = 0;
    send_count = 0;
    repeat (FRAME_CYCLES + 20) begin
      @(negedge clk);
      if (ack != 4'b0) ack_count++;
      if (tx_send) send_count++;
    end
    checkOutput("pulse_acks", ack_count, 0);
    checkOutput("pulse_sends", send_count, 0);

    // Reset in the middle of WAIT, then a fresh holdoff.
    waitIdle();
    setSlot(2, 8'h77, 8'h88);
    pushExp(8'h77, 8'h88, 2'd2);
    req = 4'b0100;
    #1;
    runGrant("pre_reset", 4'b0100, 0, 1'b1, sc);
    repeat (50) @(negedge clk);
    checkOutput("mid_wait_busy", busy, 1);
    setSlot(0, 8'h99, 8'h66);
    req   = 4'b0001;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_tx_send", tx_send, 0);
    checkOutput("rst_ack", ack, 0);
    checkOutput("rst_tx_addr", tx_addr, 0);
    checkOutput("rst_tx_code", tx_code, 0);
    checkOutput("rst_grant_id", grant_id, 0);
    checkOutput("rst_busy", busy, 1);
    repeat (3) @(negedge clk);
    pushExp(8'h99, 8'h66, 2'd0);
    rst_n = 1'b1;
    #1;
    runGrant("post_reset", 4'b0001, FRAME_CYCLES, 1'b1, sc);

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
